// File: rtl/decimating_averager.sv
`default_nettype none
// ============================================================================
// Module   : decimating_averager
// Purpose  : Block averager that sums 2^L signed input samples, emits the
//            floor-rounded mean (sum >>> L) and queues results in a small
//            output FIFO for a valid/ready consumer.
// Ports    : clk_i        - rising-edge clock
//            rst_i        - synchronous active-high reset
//            valid_i      - one-cycle strobe qualifying signal_i
//            signal_i     - signed input sample
//            log2_ratio_i - requested log2 decimation ratio (latched per block)
//            signal_o     - signed averaged sample at FIFO head (0 when empty)
//            valid_o      - FIFO non-empty
//            ready_i      - consumer pops head when valid_o & ready_i
//            overflow_o   - sticky: a result was dropped on a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module decimating_averager #(
  parameter int SIGNAL_BITS    = 24,
  parameter int MAX_LOG2_RATIO = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 valid_i,
  input  logic [SIGNAL_BITS-1:0]               signal_i,
  input  logic [$clog2(MAX_LOG2_RATIO+1)-1:0]  log2_ratio_i,
  output logic [SIGNAL_BITS-1:0]               signal_o,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic                                 overflow_o
);

  localparam int LW    = $clog2(MAX_LOG2_RATIO + 1);
  localparam int ACC_W = SIGNAL_BITS + MAX_LOG2_RATIO;
  // One extra bit so the incremented count can equal 2^MAX_LOG2_RATIO.
  localparam int CW    = MAX_LOG2_RATIO + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CW-1:0]           count_q;
  logic [LW-1:0]           l_q;

  logic [LW-1:0]           l_req_d;
  logic [LW-1:0]           l_eff_d;
  logic signed [ACC_W-1:0] sum_d;
  logic [CW-1:0]           count_d;
  logic                    last_d;
  logic [SIGNAL_BITS-1:0]  result_d;

  // ---------------------------------------------------------------------
  // Accumulation datapath
  // ---------------------------------------------------------------------
  always_comb begin
    l_req_d = (log2_ratio_i > LW'(MAX_LOG2_RATIO)) ? LW'(MAX_LOG2_RATIO)
                                                    : log2_ratio_i;
    // A block takes its ratio from the port only on its first sample.
    l_eff_d = (state_q == ST_IDLE) ? l_req_d : l_q;
    sum_d   = acc_q + {{MAX_LOG2_RATIO{signal_i[SIGNAL_BITS-1]}}, signal_i};
    count_d = count_q + CW'(1);
    last_d  = (count_d == (CW'(1) << l_eff_d));
    // Mean of 2^L samples always fits SIGNAL_BITS after the arithmetic shift.
    result_d = SIGNAL_BITS'(sum_d >>> l_eff_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      l_q     <= '0;
    end else if (valid_i) begin
      l_q <= l_eff_d;
      if (last_d) begin
        state_q <= ST_IDLE;
        acc_q   <= '0;
        count_q <= '0;
      end else begin
        state_q <= ST_ACCUM;
        acc_q   <= sum_d;
        count_q <= count_d;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output FIFO (pointers carry an extra wrap bit to tell full from empty)
  // ---------------------------------------------------------------------
  logic [SIGNAL_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_q;
  logic [PW-1:0]          rd_q;
  logic                   overflow_q;

  logic empty_d;
  logic full_d;
  logic push_d;
  logic pop_d;
  logic push_ok_d;

  always_comb begin
    empty_d   = (wr_q == rd_q);
    full_d    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    push_d    = valid_i && last_d;
    pop_d     = !empty_d && ready_i;
    // A simultaneous pop frees the slot the push lands in.
    push_ok_d = push_d && (!full_d || pop_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok_d) begin
        wr_q <= wr_q + PW'(1);
      end
      if (pop_d) begin
        rd_q <= rd_q + PW'(1);
      end
      if (push_d && full_d && !pop_d) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok_d) begin
      mem_q[wr_q[AW-1:0]] <= result_d;
    end
  end

  assign valid_o    = !empty_d;
  assign signal_o   = empty_d ? '0 : mem_q[rd_q[AW-1:0]];
  assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_decimating_averager.sv
`default_nettype none
// ============================================================================
// Module   : tb_decimating_averager
// Purpose  : Scoreboard bench for decimating_averager. A reference model
//            computes block means with plain integer arithmetic and queues
//            them; a negedge monitor compares the DUT outputs against the
//            queue head and retires entries the consumer accepts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decimating_averager;

  localparam int SB = 24;
  localparam int ML = 8;
  localparam int FD = 4;
  localparam int LW = $clog2(ML + 1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic [SB-1:0] signal_i;
  logic [LW-1:0] log2_ratio_i;
  logic [SB-1:0] signal_o;
  logic          valid_o;
  logic          ready_i;
  logic          overflow_o;

  int errors = 0;
  int checks = 0;

  decimating_averager #(
    .SIGNAL_BITS    (SB),
    .MAX_LOG2_RATIO (ML),
    .FIFO_DEPTH     (FD)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .signal_i     (signal_i),
    .log2_ratio_i (log2_ratio_i),
    .signal_o     (signal_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------
  // Reference model: collect 2^L samples, mean = floor(sum / 2^L).
  // ---------------------------------------------------------------------
  longint exp_q[$];
  bit     exp_ovf = 1'b0;
  longint blk_sum = 0;
  int     blk_n   = 0;
  int     blk_l   = 0;

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      blk_sum = 0;
      blk_n   = 0;
    end else if (valid_i) begin
      if (blk_n == 0) blk_l = (int'(log2_ratio_i) > ML) ? ML : int'(log2_ratio_i);
      blk_sum = blk_sum + longint'($signed(signal_i));
      blk_n   = blk_n + 1;
      if (blk_n == (1 << blk_l)) begin
        // The monitor has already retired any entry popped on this edge.
        if (exp_q.size() < FD) exp_q.push_back(floor_div(blk_sum, longint'(1) << blk_l));
        else exp_ovf = 1'b1;
        blk_sum = 0;
        blk_n   = 0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  always @(negedge clk_i) begin
    bit     e_valid;
    longint e_sig;
    longint a_sig;
    e_valid = (exp_q.size() != 0);
    e_sig   = e_valid ? exp_q[0] : 0;
    a_sig   = longint'($signed(signal_o));

    checks = checks + 1;
    if (valid_o !== e_valid) begin
      errors = errors + 1;
      $display("FAIL valid_o @%0t: got %b expected %b", $time, valid_o, e_valid);
    end
    checks = checks + 1;
    if ($isunknown(signal_o) || a_sig != e_sig) begin
      errors = errors + 1;
      $display("FAIL signal_o @%0t: got %0d expected %0d", $time, a_sig, e_sig);
    end
    checks = checks + 1;
    if (overflow_o !== exp_ovf) begin
      errors = errors + 1;
      $display("FAIL overflow_o @%0t: got %b expected %b", $time, overflow_o, exp_ovf);
    end
    if (ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic step(input bit v, input longint s, input int l, input bit r, input bit rs);
    valid_i      = v;
    signal_i     = SB'(s);
    log2_ratio_i = LW'(l);
    ready_i      = r;
    rst_i        = rs;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) step(1'b0, 0, 0, r, 1'b0);
  endtask

  logic [SB-1:0] rnd;

  initial begin
    valid_i = 1'b0; signal_i = '0; log2_ratio_i = '0; ready_i = 1'b0; rst_i = 1'b1;
    @(posedge clk_i); #1;
    step(1'b0, 0, 0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // L=2: 10,20,30,41 -> 25
    step(1, 10, 2, 1, 0); step(1, 20, 2, 1, 0); step(1, 30, 2, 1, 0); step(1, 41, 2, 1, 0);
    idle(3, 1'b1);

    // L=1: floor(-3.5) = -4, and full-scale pair without wrap
    step(1, -3, 1, 1, 0); step(1, -4, 1, 1, 0);
    idle(2, 1'b1);
    step(1, 24'h7FFFFF, 1, 1, 0); step(1, 24'h7FFFFF, 1, 1, 0);
    idle(2, 1'b1);
    step(1, -8388608, 1, 1, 0); step(1, -8388608, 1, 1, 0);
    idle(2, 1'b1);

    // L=0 passthrough 1..5
    for (int i = 1; i <= 5; i++) step(1, i, 0, 1, 0);
    idle(2, 1'b1);

    // Overflow: 5 pushes into a 4-deep FIFO with no consumer
    for (int i = 1; i <= 5; i++) step(1, i, 0, 0, 0);
    idle(2, 1'b0);
    idle(6, 1'b1);
    step(0, 0, 0, 1, 1);
    idle(1, 1'b1);

    // Full FIFO with simultaneous push and pop: no overflow, order kept
    for (int i = 11; i <= 14; i++) step(1, i, 0, 0, 0);
    step(1, 15, 0, 1, 0);
    step(1, 16, 0, 1, 0);
    idle(6, 1'b1);

    // Mid-block ratio change is ignored until the next block
    step(1, 100, 3, 1, 0); step(1, 200, 3, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 300 + i, 1, 1, 0);
    idle(2, 1'b1);
    step(1, 7, 1, 1, 0); step(1, 8, 1, 1, 0);
    idle(2, 1'b1);

    // Reset mid-block discards the partial sum; a sample under reset is dropped
    step(1, 50, 2, 1, 0); step(1, 50, 2, 1, 0); step(1, 50, 2, 1, 0);
    step(1, 50, 2, 1, 1);
    idle(2, 1'b1);
    for (int i = 0; i < 4; i++) step(1, 8, 2, 1, 0);
    idle(3, 1'b1);

    // Clamp: requested ratio above MAX_LOG2_RATIO acts as MAX_LOG2_RATIO
    step(1, 1000, 15, 1, 0);
    for (int i = 1; i < (1 << ML); i++) step(1, 1000 + i, 0, 1, 0);
    idle(3, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int     l;
      longint s;
      rnd = SB'($urandom);
      case ($urandom_range(0, 7))
        0:       s = 8388607;
        1:       s = -8388608;
        default: s = longint'($signed(rnd));
      endcase
      l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      step(($urandom_range(0, 1) == 1), s, l, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 299) == 0));
    end
    idle(10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decimating_averager.md
DECIMATING_AVERAGER -- requirements
Module: decimating_averager

Interface
- REQ-001: Parameter SIGNAL_BITS, default 24, width of input and output samples (signed, two's complement).
- REQ-002: Parameter MAX_LOG2_RATIO, default 8, largest supported log2 decimation ratio.
- REQ-003: Parameter FIFO_DEPTH, default 4, output FIFO entries; SHALL be a power of two >= 2.
- REQ-004: clk_i  input  1  single clock; all logic SHALL be on its rising edge.
- REQ-005: rst_i  input  1  reset; synchronous and active-high.
- REQ-006: valid_i  input  1  one-cycle strobe marking signal_i as a new sample; connects directly to the upstream filter's done-type strobe.
- REQ-007: signal_i  input  SIGNAL_BITS  signed input sample, sampled only when valid_i=1.
- REQ-008: log2_ratio_i  input  $clog2(MAX_LOG2_RATIO+1)  requested log2 of the decimation ratio N.
- REQ-009: signal_o  output  SIGNAL_BITS  signed averaged sample at the FIFO head.
- REQ-010: valid_o  output  1  high while the FIFO is non-empty.
- REQ-011: ready_i  input  1  consumer accepts the head sample on any cycle where valid_o=1 and ready_i=1.
- REQ-012: overflow_o  output  1  sticky flag; a result was dropped because the FIFO was full.

Function
- REQ-013: The accumulator SHALL be signed, SIGNAL_BITS+MAX_LOG2_RATIO bits wide, and SHALL never wrap.
- REQ-014: The effective ratio L SHALL be latched from log2_ratio_i on the first accepted sample of each block; values above MAX_LOG2_RATIO SHALL clamp to MAX_LOG2_RATIO.
- REQ-015: Changes to log2_ratio_i in mid-block SHALL be ignored until the next block starts.
- REQ-016: Block states are IDLE (count=0, no block open) and ACCUM (1 <= count < 2^L).
- REQ-017: Transitions: IDLE -> ACCUM on valid_i when L>0; ACCUM -> IDLE on the 2^L-th accepted sample.
- REQ-018: Each accepted sample SHALL be sign-extended and added to the accumulator, and the sample counter SHALL increment.
- REQ-019: On the 2^L-th sample, the result SHALL be (acc + signal_i) >>> L (arithmetic shift, rounding toward minus infinity); the result SHALL be pushed to the FIFO, and acc and count SHALL clear on that same edge.
- REQ-020: With L=0, every accepted sample SHALL be pushed unchanged, and the state SHALL stay IDLE.
- REQ-021: Latency: valid_o SHALL be high in the cycle immediately after the edge on which the completing sample was accepted, when the FIFO was previously empty.
- REQ-022: Pop: on a cycle with valid_o=1 and ready_i=1, the head SHALL be removed at the clock edge.
- REQ-023: Push with FIFO full and no pop in the same cycle: the result SHALL be dropped, overflow_o SHALL set, and FIFO contents SHALL be unchanged.
- REQ-024: Push with FIFO full and a pop in the same cycle: the push SHALL succeed, with no drop and no overflow.
- REQ-025: Push and pop in the same cycle at any fill level SHALL leave the occupancy unchanged and preserve FIFO order.
- REQ-026: signal_o SHALL be 0 whenever valid_o=0.
- REQ-027: signal_o SHALL stay stable while valid_o=1 and ready_i=0.
- REQ-028: The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit or an occupancy counter.
- REQ-029: Any valid_i pulse SHALL be accepted; the block SHALL have no input backpressure.

Reset
- REQ-030: On rst_i=1 at a clock edge, the block SHALL clear acc and count, enter IDLE, and empty the FIFO.
- REQ-031: On the same reset edge, valid_o, signal_o and overflow_o SHALL be set to 0.
- REQ-032: rst_i SHALL dominate valid_i and ready_i in the same cycle; that sample SHALL be discarded.
- REQ-033: Reset mid-block SHALL discard the partial sum; the first valid_i after reset SHALL start a new block and re-latch L.
- REQ-034: overflow_o SHALL be cleared only by reset.

Verification
- REQ-035: L=2, ready_i=1, inputs 10, 20, 30, 41 -> valid_o one cycle after the 4th sample, signal_o=25; then valid_o=0 and signal_o=0.
- REQ-036: L=1, inputs -3, -4 -> signal_o=-4 (floor of -3.5); inputs at full scale 0x7FFFFF twice with SIGNAL_BITS=24 -> signal_o=0x7FFFFF, proving no wrap.
- REQ-037: L=0, ready_i=1, 5 strobes with values 1..5 -> 5 outputs of 1..5, each one cycle after its input.
- REQ-038: FIFO_DEPTH=4, L=0, ready_i=0, 5 samples -> valid_o stays high, head=1, overflow_o=1, and draining yields 1, 2, 3, 4.
- REQ-039: FIFO full, with a push and a pop in the same cycle -> overflow_o stays 0 and the order is preserved.
- REQ-040: L=3, with log2_ratio_i changed to 1 after the 2nd sample -> the block completes after 8 samples, and the following block completes after 2 samples.
- REQ-041: Reset asserted after 3 of 4 samples in a block -> no output; then 4 samples of 8 -> signal_o=8.
